mcu_coef_scheduler: RTL
=======================

# mcu_coef_scheduler

Serializes one MCU's three zigzag-ordered 8x8 coefficient blocks (Y, U, V) into a single coefficient stream for the shared entropy coder. Sits between `zigzag_scan` and the Huffman stage: captures a block set, drives the upstream stall (`o_wait`, wired to the zigzag stage's `i_wait`), emits 192 coefficients with per-component DC differencing, and honours downstream backpressure.

## Interface
- `MCU_SIZE`, default 8: block edge; coefficients per block = MCU_SIZE*MCU_SIZE (64).
- `QUAN_BITWIDTH`, default 12: signed two's-complement quantized coefficient width.

- `clk`  in  1  clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `i_data_valid`  in  1  upstream block set valid.
- `i_zig_y`, `i_zig_u`, `i_zig_v`  in  [64][QUAN_BITWIDTH]  zigzag-ordered blocks; element 0 = DC.
- `i_last`  in  1  this MCU is the last of the image.
- `o_wait`  out  1  upstream stall.
- `o_valid`  out  1  output coefficient valid.
- `i_ready`  in  1  downstream accepts when high with `o_valid`.
- `o_coef`  out  QUAN_BITWIDTH+1  coefficient (DC as difference), signed.
- `o_comp`  out  2  component: 0=Y, 1=U, 2=V.
- `o_index`  out  6  zigzag index 0..63.
- `o_block_last`  out  1  `o_index`==63.
- `o_last`  out  1  V index 63 of the MCU captured with `i_last`=1.

## Operation
- FSM states: IDLE, SEND_Y, SEND_U, SEND_V.
- IDLE: `o_wait`=0, `o_valid`=0. When `i_data_valid`=1: latch all three blocks and `i_last` into the internal buffer; go to SEND_Y with index 0.
- SEND_x: `o_valid`=1, `o_wait`=1. Outputs are driven combinationally from the buffer, state and index registers. A transfer (`o_valid`&`i_ready`) increments the index.
- Index 63 transfer: SEND_Y->SEND_U, SEND_U->SEND_V, SEND_V->IDLE. The index wraps to 0.
- No transfer: all outputs are held stable. Changing outputs while `i_ready`=0 is a protocol violation.
- AC (index != 0): `o_coef` = sign-extended buffer value.
- DC (index 0): `o_coef` = coef - prev_dc[comp], computed at QUAN_BITWIDTH+1 bits with no overflow possible. prev_dc[comp] <= coef on the DC transfer.
- After the final V transfer of a `last` MCU, all prev_dc are cleared to 0 (new image).
- `o_wait` is a pure function of the state register (`state != IDLE`), so it is glitch-free.
  - The zigzag stage advances on the capture edge. It is then frozen holding the next block set, which is captured on the next IDLE visit.

## Timing
- Reset (async assert): state IDLE, index 0, buffer 0, prev_dc 0, captured last 0. All outputs are 0: `o_wait`, `o_valid`, `o_coef`, `o_comp`, `o_index`, `o_block_last`, `o_last`.
- Reset mid-stream abandons the MCU; no partial output follows release.
- Latency: `i_data_valid` sampled at edge N -> `o_valid`=1, Y index 0 presented in cycle N+1.
- Throughput with `i_ready` held at 1: 192 transfer cycles plus 1 mandatory IDLE cycle per MCU, i.e. 193 cycles.
- No back-to-back capture: the last V transfer always returns to IDLE, even if `i_data_valid`=1.
- `i_data_valid` while busy is ignored; the upstream is held by `o_wait`.
- `o_block_last` = (index==63) & `o_valid`.
- `o_last` = `o_block_last` & SEND_V & captured last.

## Structure
- Shared `jpeg_pkg` contains:
  - `comp_e` enum (COMP_Y=0, COMP_U=1, COMP_V=2, 2 bits);
  - `sched_state_e` (IDLE, SEND_Y, SEND_U, SEND_V);
  - localparam `COEF_PER_BLOCK`=64.
- One sub-module is natural: `dc_predictor`. It holds the three prev_dc registers, the subtractor, and the clear-on-last logic. Inputs: comp, coef, update, clear.
- Buffer, FSM and output mux stay in the top module.

## Test plan
- Reset then single MCU: Y[k]=k, U[k]=100+k, V[k]=-k, `i_ready`=1.
  - Expect 192 transfers in order; Y DC=0, U DC=100, V DC=0.
  - `o_block_last` at indices 63 only; `o_wait` high exactly 192 cycles.
- Two MCUs with Y DC 50 then 30 (U/V DC 7 then 7).
  - Expect Y DC outputs 50 then -20, U/V second DC=0.
  - 1-cycle IDLE gap between MCUs; second set captured only in that gap.
- `last` clear: MCU1 `i_last`=1 (Y DC=40), MCU2 Y DC=40 -> MCU2 Y DC output 40, not 0. `o_last` pulses once, on MCU1 V index 63.
- Backpressure: toggle `i_ready` pseudo-randomly -> no coefficient lost or duplicated; outputs stable while `o_valid`&!`i_ready`.
- Extremes (QUAN_BITWIDTH=12): prev Y DC=-2048, new=2047 -> `o_coef`=4095 in 13 bits; reverse gives -4095.
- Async reset asserted at Y index 20 -> all outputs 0 immediately; after release plus a fresh MCU, Y DC equals the raw value (prev_dc was cleared).

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types.
//   comp_e         : colour component tag carried alongside each coefficient
//   sched_state_e  : coefficient scheduler FSM states
//   COEF_PER_BLOCK : coefficients in one 8x8 block
package jpeg_pkg;

  localparam int COEF_PER_BLOCK = 64;

  typedef enum logic [1:0] {
    COMP_Y = 2'd0,
    COMP_U = 2'd1,
    COMP_V = 2'd2
  } comp_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND_Y,
    SEND_U,
    SEND_V
  } sched_state_e;

endpackage

// File: rtl/mcu_coef_scheduler_dc_predictor.sv
// Per-component DC predictor.
//   clk, n_rst : clock, async active-low reset
//   comp       : component of the coefficient being presented
//   coef       : raw DC coefficient of that component
//   update     : DC is being transferred; remember it as the new prediction
//   clear      : end of image; all predictions return to 0 (wins over update)
//   diff       : coef - prev_dc[comp], one bit wider so it cannot overflow
module dc_predictor
  import jpeg_pkg::*;
#(
  parameter int QUAN_BITWIDTH = 12
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  comp_e                           comp,
  input  logic signed [QUAN_BITWIDTH-1:0] coef,
  input  logic                            update,
  input  logic                            clear,
  output logic signed [QUAN_BITWIDTH:0]   diff
);

  logic signed [QUAN_BITWIDTH-1:0] prev_y, prev_u, prev_v, prev_sel;

  always_comb begin
    prev_sel = '0;
    case (comp)
      COMP_Y:  prev_sel = prev_y;
      COMP_U:  prev_sel = prev_u;
      COMP_V:  prev_sel = prev_v;
      default: prev_sel = '0;
    endcase
  end

  // Manual sign extension; the W+1-bit result holds any W-bit difference exactly.
  assign diff = {coef[QUAN_BITWIDTH-1], coef} - {prev_sel[QUAN_BITWIDTH-1], prev_sel};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_y <= '0;
      prev_u <= '0;
      prev_v <= '0;
    end else if (clear) begin
      prev_y <= '0;
      prev_u <= '0;
      prev_v <= '0;
    end else if (update) begin
      case (comp)
        COMP_Y:  prev_y <= coef;
        COMP_U:  prev_u <= coef;
        COMP_V:  prev_v <= coef;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mcu_coef_scheduler.sv
// Serializes one MCU (Y, U, V zigzag blocks) into a single coefficient stream
// with per-component DC differencing and ready/valid backpressure.
//   clk, n_rst              : clock, async active-low reset
//   i_data_valid            : upstream block set valid (captured only in IDLE)
//   i_zig_y/u/v             : zigzag-ordered blocks, element 0 = DC
//   i_last                  : captured MCU is the last of the image
//   o_wait                  : upstream stall, high while a block set is being sent
//   o_valid / i_ready       : output handshake
//   o_coef, o_comp, o_index : coefficient (DC as difference), component, zigzag index
//   o_block_last, o_last    : index 63 of any block / of V in the last MCU
//
// state  | meaning
// IDLE   | buffer free, capture next block set on i_data_valid
// SEND_Y | streaming Y block from buffer
// SEND_U | streaming U block from buffer
// SEND_V | streaming V block; index 63 transfer always returns to IDLE
module mcu_coef_scheduler
  import jpeg_pkg::*;
#(
  parameter int MCU_SIZE      = 8,
  parameter int QUAN_BITWIDTH = 12
) (
  input  logic                                                clk,
  input  logic                                                n_rst,
  input  logic                                                i_data_valid,
  input  logic [MCU_SIZE*MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]     i_zig_y,
  input  logic [MCU_SIZE*MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]     i_zig_u,
  input  logic [MCU_SIZE*MCU_SIZE-1:0][QUAN_BITWIDTH-1:0]     i_zig_v,
  input  logic                                                i_last,
  output logic                                                o_wait,
  output logic                                                o_valid,
  input  logic                                                i_ready,
  output logic signed [QUAN_BITWIDTH:0]                       o_coef,
  output logic [1:0]                                          o_comp,
  output logic [$clog2(MCU_SIZE*MCU_SIZE)-1:0]                o_index,
  output logic                                                o_block_last,
  output logic                                                o_last
);

  localparam int NCOEF = MCU_SIZE * MCU_SIZE;
  localparam int IDX_W = $clog2(NCOEF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCOEF - 1);

  sched_state_e state, next_state;
  logic [IDX_W-1:0] idx;
  logic [NCOEF-1:0][QUAN_BITWIDTH-1:0] buf_y, buf_u, buf_v;
  logic last_q;

  logic send, xfer, at_last, capture;
  logic signed [QUAN_BITWIDTH-1:0] sel_coef;
  logic signed [QUAN_BITWIDTH:0]   dc_diff;
  comp_e cur_comp;

  assign send    = (state != IDLE);
  assign xfer    = send & i_ready;
  assign at_last = (idx == IDX_LAST);
  assign capture = (state == IDLE) & i_data_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_data_valid)    next_state = SEND_Y;
      SEND_Y:  if (xfer && at_last) next_state = SEND_U;
      SEND_U:  if (xfer && at_last) next_state = SEND_V;
      SEND_V:  if (xfer && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Index wraps naturally from 63 to 0 on the last transfer of each block.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    idx <= '0;
    else if (xfer) idx <= idx + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buf_y  <= '0;
      buf_u  <= '0;
      buf_v  <= '0;
      last_q <= 1'b0;
    end else if (capture) begin
      buf_y  <= i_zig_y;
      buf_u  <= i_zig_u;
      buf_v  <= i_zig_v;
      last_q <= i_last;
    end
  end

  always_comb begin
    sel_coef = '0;
    cur_comp = COMP_Y;
    case (state)
      SEND_Y: begin sel_coef = buf_y[idx]; cur_comp = COMP_Y; end
      SEND_U: begin sel_coef = buf_u[idx]; cur_comp = COMP_U; end
      SEND_V: begin sel_coef = buf_v[idx]; cur_comp = COMP_V; end
      default: ;
    endcase
  end

  dc_predictor #(.QUAN_BITWIDTH(QUAN_BITWIDTH)) u_dc_predictor (
    .clk    (clk),
    .n_rst  (n_rst),
    .comp   (cur_comp),
    .coef   (sel_coef),
    .update (xfer & (idx == '0)),
    .clear  (xfer & at_last & (state == SEND_V) & last_q),
    .diff   (dc_diff)
  );

  assign o_wait       = send;
  assign o_valid      = send;
  assign o_comp       = cur_comp;
  assign o_index      = idx;
  assign o_block_last = send & at_last;
  assign o_last       = o_block_last & (state == SEND_V) & last_q;

  // In IDLE the predictor still produces 0 - prev_dc, so the output is gated.
  always_comb begin
    o_coef = '0;
    if (send) begin
      if (idx == '0) o_coef = dc_diff;
      else           o_coef = {sel_coef[QUAN_BITWIDTH-1], sel_coef};
    end
  end

endmodule
